itof_seq: RTL and testbench
===========================

ITOF_SEQ -- requirements
Module: itof_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: x and rm are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-005 SHALL have port x, input, 32 bits: signed two's-complement integer operand.
REQ-006 SHALL have port rm, input, 1 bit: rounding mode; 0 = truncate toward zero, 1 = round to nearest by magnitude, ties away from zero.
REQ-007 SHALL have port y, output, 32 bits: IEEE-754 single-precision result.
REQ-008 SHALL have port out_valid, output, 1 bit: y holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes y.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, NORM, RND, OUT; in_ready = (state==IDLE) and not rst; out_valid = (state==OUT).
REQ-012 Accept SHALL occur on a rising edge with in_valid and in_ready both high; x and rm are captured; in_valid SHALL be ignored in every other state.
REQ-013 On accept: sign s = x[31]; magnitude m = |x| as unsigned 32 bits; x = 0x80000000 SHALL give m = 0x80000000; exponent register e is loaded with 158.
REQ-014 On accept with m = 0: y SHALL be loaded with 0x00000000 and the next state SHALL be OUT.
REQ-015 On accept with m != 0: the next state SHALL be NORM.
REQ-016 In NORM with m[31] = 0: each cycle SHALL shift m left by 1 and decrement e by 1.
REQ-017 In NORM with m[31] = 1: the next state SHALL be RND.
REQ-018 Normalization SHALL take exactly one cycle per leading zero; no priority encoder is used.
REQ-019 In RND: mantissa f = m[30:8] and guard g = m[7].
REQ-020 In RND, if rm = 1 and g = 1: f SHALL be incremented by 1.
REQ-021 In RND, if the increment of REQ-020 carries out of 23 bits: f = 0 and e = e + 1.
REQ-022 In RND: y SHALL be loaded with {s, e[7:0], f} and the next state SHALL be OUT.
REQ-023 Bits m[6:0] SHALL not affect the result.
REQ-024 No overflow, NaN, infinity or denormal output SHALL be possible; e stays within 127..158.
REQ-025 Latency, counted from the accept edge: out_valid SHALL first be high in cycle 1 for m = 0, and in cycle lz+3 for m != 0, where lz = leading zeros of m (0..31).
REQ-026 In OUT, y and out_valid SHALL hold stable until out_ready is high on a rising edge; the next state is then IDLE.
REQ-027 There SHALL be no same-edge re-accept: in_ready rises one cycle after the output handshake.
REQ-028 Throughput SHALL be one operation in flight at a time.

Reset
REQ-029 While rst is high at a rising edge: the next state SHALL be IDLE, y = 0, out_valid = 0, busy = 0, e = 0, m = 0.
REQ-030 in_ready SHALL be 0 during a reset cycle and 1 in the first cycle after rst falls.
REQ-031 rst asserted in NORM, RND or OUT SHALL abort the operation with no output handshake; the aborted result is never presented.

Verification
REQ-032 x=0x00000001, rm=0 -> y=0x3F800000; out_valid first high in cycle 34 after accept.
REQ-033 x=0xFFFFFFFF (-1) -> y=0xBF800000.
REQ-034 x=0x80000000 -> y=0xCF000000 in cycle 3.
REQ-035 x=0x00000000 -> y=0x00000000 in cycle 1.
REQ-036 x=0x7FFFFFFF: rm=0 -> y=0x4EFFFFFF; rm=1 -> y=0x4F000000 (mantissa carry into exponent).
REQ-037 x=0x01000001: rm=0 -> y=0x4B800000; rm=1 -> y=0x4B800001 (tie away from zero).
REQ-038 Hold out_ready=0 for 5 cycles in OUT -> y and out_valid stable and in_ready=0 throughout.
REQ-039 Assert rst mid-NORM -> next cycle in IDLE, out_valid=0, y=0; following accept of x=2 -> y=0x40000000.

Source files
------------

// File: rtl/itof_seq_if.sv
// ============================================================================
//  Module      : itof_seq_if
//  Description : Handshake bundle for the sequential int32 -> float32
//                converter. The operand side uses in_valid/in_ready and the
//                result side uses out_valid/out_ready.
//  Ports       : in_valid, x, rm, out_ready   (master -> slave)
//                in_ready, y, out_valid, busy (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface itof_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        rm;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    // Producer/consumer side (drives operands, takes results)
    modport master (
        output in_valid, x, rm, out_ready,
        input  in_ready, y, out_valid, busy
    );

    // Converter side
    modport slave (
        input  in_valid, x, rm, out_ready,
        output in_ready, y, out_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/itof_seq.sv
// ============================================================================
//  Module      : itof_seq
//  Description : Sequential signed 32-bit integer to IEEE-754 single-precision
//                converter. Normalises the magnitude one bit per cycle (no
//                priority encoder), then rounds on the guard bit only, using
//                either truncation or round-to-nearest with ties away from
//                zero.
//  Ports       : clk  - clock, rising edge active
//                rst  - synchronous, active-high reset
//                bus  - itof_seq_if.slave: in_valid/in_ready/x/rm operand
//                       handshake, y/out_valid/out_ready result handshake,
//                       busy status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module itof_seq (
    input  logic          clk,
    input  logic          rst,
    itof_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Exponent of a value whose MSB sits at bit 31: 127 + 31
    localparam logic [7:0] C_EXP_INIT = 8'd158;

    state_t      r_state;
    logic        r_sign;
    logic        r_rm;
    logic [31:0] r_m;
    logic [7:0]  r_e;
    logic [31:0] r_y;
    logic        r_out_valid;
    logic        r_busy;

    logic        w_in_ready;
    logic        w_accept;
    logic [31:0] w_mag;
    logic [22:0] w_frac;
    logic        w_guard;
    logic [23:0] w_frac_sum;
    logic        w_carry;
    logic [7:0]  w_exp_rnd;

    // Reset masks in_ready combinationally so no operand can be taken on a
    // reset edge.
    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude of INT_MIN.
    assign w_mag = bus.x[31] ? (~bus.x + 32'd1) : bus.x;

    // Rounding datapath. Only the guard bit participates; m[6:0] is dropped.
    // A carry out of the 23-bit fraction leaves the low 23 bits at zero,
    // which is exactly the renormalised fraction of 1.0 * 2^(e+1).
    assign w_frac     = r_m[30:8];
    assign w_guard    = r_m[7];
    assign w_frac_sum = {1'b0, w_frac} + {23'd0, (r_rm & w_guard)};
    assign w_carry    = w_frac_sum[23];
    assign w_exp_rnd  = r_e + {7'd0, w_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_rm        <= 1'b0;
            r_m         <= 32'd0;
            r_e         <= 8'd0;
            r_y         <= 32'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= bus.x[31];
                        r_rm   <= bus.rm;
                        r_m    <= w_mag;
                        r_e    <= C_EXP_INIT;
                        r_busy <= 1'b1;
                        if (w_mag == 32'd0) begin
                            // Zero has no leading one to find: present +0 now.
                            r_y         <= 32'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end

                S_NORM: begin
                    // One leading zero removed per cycle.
                    if (r_m[31]) begin
                        r_state <= S_RND;
                    end else begin
                        r_m <= {r_m[30:0], 1'b0};
                        r_e <= r_e - 8'd1;
                    end
                end

                S_RND: begin
                    r_e         <= w_exp_rnd;
                    r_y         <= {r_sign, w_exp_rnd, w_frac_sum[22:0]};
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.y         = r_y;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_itof_seq.sv
// ============================================================================
//  Module      : tb_itof_seq
//  Description : Self-checking bench for itof_seq. Expected results and
//                latencies come from an arithmetic reference model of the
//                int32 -> float32 conversion.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_itof_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    itof_seq_if bus ();

    itof_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact value |x| = mag, scaled so the leading one lands at
    // bit 32 of a 64-bit word; the result significand is the top 24 bits,
    // and the bit just below them is the half-ulp used for rounding.
    function automatic logic [31:0] ref_itof(input logic [31:0] xv, input logic rmv,
                                             output int lat);
        longint unsigned mag;
        longint unsigned frac;
        longint unsigned sig;
        int              k;
        logic            s;
        logic [7:0]      be;
        s   = xv[31];
        mag = s ? (64'd4294967296 - {32'd0, xv}) : {32'd0, xv};
        if (mag == 64'd0) begin
            lat = 1;
            return 32'd0;
        end
        k = 0;
        while ((64'd1 << (k + 1)) <= mag) k++;
        lat  = (31 - k) + 3;
        frac = (mag << 32) >> k;
        if (rmv) frac = frac + 64'd256;
        sig = frac >> 9;
        if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            k   = k + 1;
        end
        be = 8'(k + 127);
        return {s, be, sig[22:0]};
    endfunction

    task automatic do_op(input logic [31:0] xv, input logic rmv, input int hold,
                         input bit use_const, input logic [31:0] const_y, input string tag);
        int          lat_exp;
        int          cyc;
        logic [31:0] y_exp;
        y_exp = ref_itof(xv, rmv, lat_exp);
        if (use_const) y_exp = const_y;

        check_val({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.rm       = rmv;
        @(posedge clk);
        @(negedge clk);
        // Junk operand with in_valid still high must be ignored while busy.
        bus.x  = $urandom;
        bus.rm = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, ".latency"}, 32'(cyc), 32'(lat_exp));
        check_val({tag, ".y"}, bus.y, y_exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val({tag, ".hold_y"}, bus.y, y_exp);
            check_val({tag, ".hold_ov"}, {31'd0, bus.out_valid}, 32'd1);
            check_val({tag, ".hold_ir"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, ".post_ov"}, {31'd0, bus.out_valid}, 32'd0);
        check_val({tag, ".post_ir"}, {31'd0, bus.in_ready}, 32'd1);
        check_val({tag, ".post_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    logic [31:0] d_x   [10];
    logic        d_rm  [10];
    logic [31:0] d_y   [10];

    initial begin
        int          ov_seen;
        logic [31:0] rx;

        d_x[0] = 32'h0000_0001; d_rm[0] = 1'b0; d_y[0] = 32'h3F80_0000;
        d_x[1] = 32'hFFFF_FFFF; d_rm[1] = 1'b0; d_y[1] = 32'hBF80_0000;
        d_x[2] = 32'h8000_0000; d_rm[2] = 1'b0; d_y[2] = 32'hCF00_0000;
        d_x[3] = 32'h0000_0000; d_rm[3] = 1'b0; d_y[3] = 32'h0000_0000;
        d_x[4] = 32'h7FFF_FFFF; d_rm[4] = 1'b0; d_y[4] = 32'h4EFF_FFFF;
        d_x[5] = 32'h7FFF_FFFF; d_rm[5] = 1'b1; d_y[5] = 32'h4F00_0000;
        d_x[6] = 32'h0100_0001; d_rm[6] = 1'b0; d_y[6] = 32'h4B80_0000;
        d_x[7] = 32'h0100_0001; d_rm[7] = 1'b1; d_y[7] = 32'h4B80_0001;
        d_x[8] = 32'h8000_0000; d_rm[8] = 1'b1; d_y[8] = 32'hCF00_0000;
        d_x[9] = 32'h0000_0000; d_rm[9] = 1'b1; d_y[9] = 32'h0000_0000;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = 32'd0;
        bus.rm        = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
        check_val("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst.busy",      {31'd0, bus.busy},      32'd0);
        check_val("rst.y",         bus.y,                  32'd0);
        rst = 1'b0;
        #1;
        check_val("rst.in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Directed vectors; the -1 case also holds the result for 5 cycles.
        for (int i = 0; i < 10; i++)
            do_op(d_x[i], d_rm[i], (i == 1) ? 5 : 0, 1'b1, d_y[i], $sformatf("dir%0d", i));

        // Abort mid-normalisation.
        bus.in_valid = 1'b1;
        bus.x        = 32'h0000_0001;
        bus.rm       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("abort.busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("abort.in_ready", {31'd0, bus.in_ready},  32'd0);
        check_val("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("abort.y",        bus.y,                  32'd0);
        check_val("abort.busy",     {31'd0, bus.busy},      32'd0);
        rst = 1'b0;
        #1;
        check_val("abort.in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) ov_seen++;
            @(negedge clk);
        end
        check_val("abort.no_output", 32'(ov_seen), 32'd0);
        do_op(32'h0000_0002, 1'b0, 0, 1'b1, 32'h4000_0000, "abort.x2");

        // Randomised operands spread across all leading-zero counts.
        for (int i = 0; i < 60; i++) begin
            rx = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rx = -rx;
            do_op(rx, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'b0, 32'd0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
